decode_stage_hz: RTL and testbench
==================================

Name: decode_stage_hz

Overview:
- Parametrised successor of the pipeline decode stage: decodes one 32-bit instruction per cycle and reads a 2R/1W register file with write-through bypass from WB.
- Generates sign-extended immediates and control bundles, then loads the ID/EX pipeline register.
- Adds three behaviours the earlier stage does not have: valid tracking, load-use hazard stall with bubble insertion, and branch flush.
- Sits between the IF/ID register (stage 1) and the EX stage (stage 3).

Parameters:
- XLEN, 32, register/data/immediate width (32 or 64).
- NREGS, 32, implemented architectural registers (16 or 32). Indices >= NREGS read 0 and ignore writes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ifidValid  in  1  IF/ID holds a real instruction.
- ifidInst  in  32  instruction.
- ifidPc  in  32  instruction PC.
- flush  in  1  taken branch/jump from EX; squash the instruction in decode.
- regWriteEnable  in  1  WB write strobe.
- writeReg  in  5  WB destination register.
- writeData  in  XLEN  WB write value.
- stall  out  1  combinational; upstream holds PC and IF/ID this cycle.
- idexValid  out  1  ID/EX holds a real instruction.
- idexPc  out  32  forwarded PC.
- idexData1, idexData2  out  XLEN  rs1/rs2 read values.
- idexRs1, idexRs2, idexRd  out  5  register indices.
- idexFunc7  out  7  inst[31:25].
- idexFunc3  out  3  inst[14:12].
- idexImm  out  XLEN  sign-extended immediate.
- idexExCtrl  out  3  {aluSrc, aluOp[1:0]}.
- idexMemCtrl  out  3  {branch, memRead, memWrite}.
- idexWbCtrl  out  2  {regWrite, memToReg}.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0, every ID/EX output and every register-file entry is 0. stall is 0 during reset.
- Register file:
  - x0 always reads 0 and ignores writes.
  - Writes take effect on the clk edge.
  - Same-cycle read of a register being written (regWriteEnable=1, writeReg==rs, rs!=0, rs<NREGS) returns writeData (write-through bypass).
- Decode by opcode = inst[6:0] (ex/mem/wb, imm type):
  - 0110011 R: 010/000/10, imm 0.
  - 0010011 I-ALU: 110/000/10, I-imm.
  - 0000011 load: 100/010/11, I-imm.
  - 0100011 store: 100/001/00, S-imm.
  - 1100011 branch: 001/100/00, B-imm.
  - 1101111 JAL: 111/100/10, J-imm.
  - 1100111 JALR: 111/100/10, I-imm.
  - 0110111 LUI, 0010111 AUIPC: 111/000/10, U-imm.
  - Any other opcode: all control 0, imm 0.
  - Immediates are sign-extended from inst[31] to XLEN; U-imm is inst[31:12]<<12, then sign-extended.
- Load-use hazard: stall=1 when all of the following hold:
  - ifidValid=1, idexValid=1, idexMemCtrl[1]=1;
  - idexRd!=0;
  - idexRd==inst[19:15], or idexRd==inst[24:20] and the opcode uses rs2 (R, store, branch).
- Next-state per clk edge, in priority order:
  1. flush=1: load a bubble. stall is forced to 0 the same cycle.
  2. stall=1: load a bubble.
  3. Otherwise: load the decoded instruction with idexValid=ifidValid. Control fields are zeroed when ifidValid=0.
  - A bubble means idexValid=0 and all ctrl fields 0. Data, PC, indices and imm fields are don't-care but are loaded as zero.
- Latency: one cycle from IF/ID to ID/EX. A load-use stall costs exactly one bubble, because the next cycle's idexMemCtrl[1] is 0.
- Reset asserted mid-stream: outputs clear immediately. The first valid instruction after rst_n rises appears one cycle after it is presented.

Optional Feature:
- DECODE_HAZARD_EN.
  - Defined: load-use detection and stall as described above.
  - Undefined: stall is tied 0 and no hazard bubbles are inserted; the compiler/software guarantees spacing. Flush and valid behaviour are unchanged.

Test Plan:
- Reset: drive rst_n=0 mid-operation → all idex* outputs 0 asynchronously; registers x1..x31 read 0 afterwards.
- Bypass and x0: WB writes x5=0xDEADBEEF in the same cycle as decoding add x6,x5,x0 → idexData1=0xDEADBEEF, idexData2=0, idexExCtrl=010, idexWbCtrl=10. A write to x0 → x0 still reads 0.
- Immediates: beq x0,x0,-8 (0xFE000CE3) → idexImm=0xFFFFFFF8, idexMemCtrl=100. lui x1,0x80000 → idexImm=0x80000000 (0xFFFFFFFF80000000 with XLEN=64).
- Load-use (DECODE_HAZARD_EN defined): lw x2,0(x1) then add x3,x2,x4 → stall=1 for exactly one cycle, one bubble (idexValid=0, ctrl 0), then the add issues with idexValid=1. With the macro undefined → stall never asserts.
- Flush priority: flush=1 while stall would assert → stall=0 and next idexValid=0. With ifidValid=0 → idexValid=0 and ctrl 0.
- NREGS=16: write x20 then read it → reads 0; lw x20 followed by a use of x20 still triggers the index-based stall.

Source files
------------

// File: rtl/decode_stage_hz.sv
// Pipeline decode stage with valid tracking, load-use stall and branch flush.
// Reads a 2R/1W register file with write-through bypass from WB, builds
// sign-extended immediates and control bundles, and loads the ID/EX register.
// Optional build macro: DECODE_HAZARD_EN enables load-use detection and stall;
// when undefined, stall is tied low and spacing is left to software.
module decode_stage_hz #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ifidValid,
  input  logic [31:0]     ifidInst,
  input  logic [31:0]     ifidPc,
  input  logic            flush,
  input  logic            regWriteEnable,
  input  logic [4:0]      writeReg,
  input  logic [XLEN-1:0] writeData,
  output logic            stall,
  output logic            idexValid,
  output logic [31:0]     idexPc,
  output logic [XLEN-1:0] idexData1,
  output logic [XLEN-1:0] idexData2,
  output logic [4:0]      idexRs1,
  output logic [4:0]      idexRs2,
  output logic [4:0]      idexRd,
  output logic [6:0]      idexFunc7,
  output logic [2:0]      idexFunc3,
  output logic [XLEN-1:0] idexImm,
  output logic [2:0]      idexExCtrl,
  output logic [2:0]      idexMemCtrl,
  output logic [1:0]      idexWbCtrl
);

  localparam int unsigned IdxW = $clog2(NREGS);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic [31:0]     pc;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      func7;
    logic [2:0]      func3;
    logic [XLEN-1:0] imm;
    logic [2:0]      ex_ctrl;
    logic [2:0]      mem_ctrl;
    logic [1:0]      wb_ctrl;
  } idex_t;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  assign opcode = ifidInst[6:0];
  assign rs1    = ifidInst[19:15];
  assign rs2    = ifidInst[24:20];
  assign rd     = ifidInst[11:7];

  // Register file; entry 0 is never written so it stays at its reset value of 0
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];

  // Next register-file contents: WB write, ignoring x0 and unimplemented indices
  always_comb begin
    rf_d = rf_q;
    if (regWriteEnable && (writeReg != 5'd0) && (32'(writeReg) < NREGS)) begin
      rf_d[writeReg[IdxW-1:0]] = writeData;
    end
  end

  // Register-file state, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q <= '{default: '0};
    end else begin
      rf_q <= rf_d;
    end
  end

  // Read ports with write-through bypass so WB and decode can share a cycle
  logic [XLEN-1:0] rd_data1, rd_data2;
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if ((rs1 != 5'd0) && (32'(rs1) < NREGS)) begin
      if (regWriteEnable && (writeReg == rs1)) rd_data1 = writeData;
      else                                     rd_data1 = rf_q[rs1[IdxW-1:0]];
    end
    if ((rs2 != 5'd0) && (32'(rs2) < NREGS)) begin
      if (regWriteEnable && (writeReg == rs2)) rd_data2 = writeData;
      else                                     rd_data2 = rf_q[rs2[IdxW-1:0]];
    end
  end

  // Immediate candidates, each sign-extended from inst[31]
  logic [11:0] imm_i12, imm_s12;
  logic [12:0] imm_b13;
  logic [20:0] imm_j21;
  logic [31:0] imm_u32;
  assign imm_i12 = ifidInst[31:20];
  assign imm_s12 = {ifidInst[31:25], ifidInst[11:7]};
  assign imm_b13 = {ifidInst[31], ifidInst[7], ifidInst[30:25], ifidInst[11:8], 1'b0};
  assign imm_j21 = {ifidInst[31], ifidInst[19:12], ifidInst[20], ifidInst[30:21], 1'b0};
  assign imm_u32 = {ifidInst[31:12], 12'b0};

  // Opcode decode into control bundles and immediate
  logic [2:0]      dec_ex, dec_mem;
  logic [1:0]      dec_wb;
  logic [XLEN-1:0] dec_imm;
  always_comb begin
    dec_ex  = 3'b000;
    dec_mem = 3'b000;
    dec_wb  = 2'b00;
    dec_imm = '0;
    case (opcode)
      OpR: begin
        dec_ex = 3'b010; dec_wb = 2'b10;
      end
      OpIAlu: begin
        dec_ex = 3'b110; dec_wb = 2'b10; dec_imm = XLEN'($signed(imm_i12));
      end
      OpLoad: begin
        dec_ex = 3'b100; dec_mem = 3'b010; dec_wb = 2'b11;
        dec_imm = XLEN'($signed(imm_i12));
      end
      OpStore: begin
        dec_ex = 3'b100; dec_mem = 3'b001; dec_imm = XLEN'($signed(imm_s12));
      end
      OpBr: begin
        dec_ex = 3'b001; dec_mem = 3'b100; dec_imm = XLEN'($signed(imm_b13));
      end
      OpJal: begin
        dec_ex = 3'b111; dec_mem = 3'b100; dec_wb = 2'b10;
        dec_imm = XLEN'($signed(imm_j21));
      end
      OpJalr: begin
        dec_ex = 3'b111; dec_mem = 3'b100; dec_wb = 2'b10;
        dec_imm = XLEN'($signed(imm_i12));
      end
      OpLui, OpAuipc: begin
        dec_ex = 3'b111; dec_wb = 2'b10; dec_imm = XLEN'($signed(imm_u32));
      end
      default: ;
    endcase
  end

  idex_t idex_q, idex_d;

`ifdef DECODE_HAZARD_EN
  // Only R, store and branch actually consume rs2, so only they can hit on it
  logic uses_rs2, load_use;
  assign uses_rs2 = (opcode == OpR) || (opcode == OpStore) || (opcode == OpBr);
  assign load_use = ifidValid && idex_q.valid && idex_q.mem_ctrl[1] &&
                    (idex_q.rd != 5'd0) &&
                    ((idex_q.rd == rs1) || ((idex_q.rd == rs2) && uses_rs2));
  // A flush squashes the dependent instruction anyway, so it overrides the stall
  assign stall = load_use && !flush;
`else
  assign stall = 1'b0;
`endif

  // ID/EX next state: bubble on flush or stall, otherwise the decoded instruction
  always_comb begin
    idex_d = '0;
    if (!flush && !stall) begin
      idex_d.valid = ifidValid;
      idex_d.pc    = ifidPc;
      idex_d.data1 = rd_data1;
      idex_d.data2 = rd_data2;
      idex_d.rs1   = rs1;
      idex_d.rs2   = rs2;
      idex_d.rd    = rd;
      idex_d.func7 = ifidInst[31:25];
      idex_d.func3 = ifidInst[14:12];
      idex_d.imm   = dec_imm;
      if (ifidValid) begin
        idex_d.ex_ctrl  = dec_ex;
        idex_d.mem_ctrl = dec_mem;
        idex_d.wb_ctrl  = dec_wb;
      end
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign idexValid   = idex_q.valid;
  assign idexPc      = idex_q.pc;
  assign idexData1   = idex_q.data1;
  assign idexData2   = idex_q.data2;
  assign idexRs1     = idex_q.rs1;
  assign idexRs2     = idex_q.rs2;
  assign idexRd      = idex_q.rd;
  assign idexFunc7   = idex_q.func7;
  assign idexFunc3   = idex_q.func3;
  assign idexImm     = idex_q.imm;
  assign idexExCtrl  = idex_q.ex_ctrl;
  assign idexMemCtrl = idex_q.mem_ctrl;
  assign idexWbCtrl  = idex_q.wb_ctrl;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Self-checking bench for decode_stage_hz: table of directed vectors plus
// hand-written sequences for load-use, flush priority, reset and NREGS=16.
module tb_decode_stage_hz;

`ifdef DECODE_HAZARD_EN
  localparam bit Hz = 1'b1;
`else
  localparam bit Hz = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifid_valid = 1'b0;
  logic [31:0] ifid_inst = '0;
  logic [31:0] ifid_pc = '0;
  logic        flush = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wreg = '0;
  logic [31:0] wdata = '0;

  logic        stall, valid;
  logic [31:0] pc, d1, d2, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  f7;
  logic [2:0]  f3, exc, memc;
  logic [1:0]  wbc;

  logic        stall_s, valid_s;
  logic [31:0] pc_s, d1_s, d2_s, imm_s;
  logic [4:0]  rs1_s, rs2_s, rd_s;
  logic [6:0]  f7_s;
  logic [2:0]  f3_s, exc_s, memc_s;
  logic [1:0]  wbc_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_hz #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .ifidValid(ifid_valid), .ifidInst(ifid_inst),
    .ifidPc(ifid_pc), .flush(flush), .regWriteEnable(we), .writeReg(wreg),
    .writeData(wdata), .stall(stall), .idexValid(valid), .idexPc(pc),
    .idexData1(d1), .idexData2(d2), .idexRs1(rs1), .idexRs2(rs2), .idexRd(rd),
    .idexFunc7(f7), .idexFunc3(f3), .idexImm(imm), .idexExCtrl(exc),
    .idexMemCtrl(memc), .idexWbCtrl(wbc)
  );

  decode_stage_hz #(.XLEN(32), .NREGS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .ifidValid(ifid_valid), .ifidInst(ifid_inst),
    .ifidPc(ifid_pc), .flush(flush), .regWriteEnable(we), .writeReg(wreg),
    .writeData(wdata), .stall(stall_s), .idexValid(valid_s), .idexPc(pc_s),
    .idexData1(d1_s), .idexData2(d2_s), .idexRs1(rs1_s), .idexRs2(rs2_s),
    .idexRd(rd_s), .idexFunc7(f7_s), .idexFunc3(f3_s), .idexImm(imm_s),
    .idexExCtrl(exc_s), .idexMemCtrl(memc_s), .idexWbCtrl(wbc_s)
  );

  typedef struct {
    logic        v;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fl;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        e_v;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic [2:0]  e_ex;
    logic [2:0]  e_mem;
    logic [1:0]  e_wb;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_pc"}, 64'(pc), 64'd0);
    chk({tag, "_d1"}, 64'(d1), 64'd0);
    chk({tag, "_d2"}, 64'(d2), 64'd0);
    chk({tag, "_idx"}, 64'({rs1, rs2, rd}), 64'd0);
    chk({tag, "_func"}, 64'({f7, f3}), 64'd0);
    chk({tag, "_imm"}, 64'(imm), 64'd0);
    chk({tag, "_ctrl"}, 64'({exc, memc, wbc}), 64'd0);
    chk({tag, "_stall"}, 64'(stall), 64'd0);
  endtask

  // Drive one cycle of inputs at the falling edge
  task automatic drive(input logic v, input logic [31:0] inst, input logic fl,
                       input logic w, input logic [4:0] wr, input logic [31:0] wd);
    @(negedge clk);
    ifid_valid = v;
    ifid_inst  = inst;
    ifid_pc    = 32'h200;
    flush      = fl;
    we         = w;
    wreg       = wr;
    wdata      = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // inputs                                        expected after edge
    vt[0]  = '{1, 32'h00028333, 32'h100, 0, 1, 5'd5, 32'hDEADBEEF,
               1, 32'hDEADBEEF, 32'h0, 32'h0, 5'd6, 3'b010, 3'b000, 2'b10};
    vt[1]  = '{1, 32'h00028333, 32'h104, 0, 0, 5'd0, 32'h0,
               1, 32'hDEADBEEF, 32'h0, 32'h0, 5'd6, 3'b010, 3'b000, 2'b10};
    vt[2]  = '{1, 32'h00500433, 32'h108, 0, 1, 5'd0, 32'h12345678,
               1, 32'h0, 32'hDEADBEEF, 32'h0, 5'd8, 3'b010, 3'b000, 2'b10};
    vt[3]  = '{1, 32'h000004B3, 32'h10C, 0, 0, 5'd0, 32'h0,
               1, 32'h0, 32'h0, 32'h0, 5'd9, 3'b010, 3'b000, 2'b10};
    vt[4]  = '{1, 32'hFE000CE3, 32'h110, 0, 0, 5'd0, 32'h0,
               1, 32'h0, 32'h0, 32'hFFFFFFF8, 5'd25, 3'b001, 3'b100, 2'b00};
    vt[5]  = '{1, 32'h800000B7, 32'h114, 0, 0, 5'd0, 32'h0,
               1, 32'h0, 32'h0, 32'h80000000, 5'd1, 3'b111, 3'b000, 2'b10};
    vt[6]  = '{1, 32'hFFF00393, 32'h118, 0, 0, 5'd0, 32'h0,
               1, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd7, 3'b110, 3'b000, 2'b10};
    vt[7]  = '{1, 32'hFE532E23, 32'h11C, 0, 0, 5'd0, 32'h0,
               1, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFC, 5'd28, 3'b100, 3'b001, 2'b00};
    vt[8]  = '{1, 32'h008000EF, 32'h120, 0, 0, 5'd0, 32'h0,
               1, 32'h0, 32'h0, 32'h8, 5'd1, 3'b111, 3'b100, 2'b10};
    vt[9]  = '{1, 32'h0000007F, 32'h124, 0, 0, 5'd0, 32'h0,
               1, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000, 3'b000, 2'b00};
    vt[10] = '{0, 32'h00028333, 32'h128, 0, 0, 5'd0, 32'h0,
               0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd6, 3'b000, 3'b000, 2'b00};
    vt[11] = '{1, 32'h00028333, 32'h12C, 1, 0, 5'd0, 32'h0,
               0, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000, 3'b000, 2'b00};
    vt[12] = '{1, 32'h0000A103, 32'h130, 0, 0, 5'd0, 32'h0,
               1, 32'h0, 32'h0, 32'h0, 5'd2, 3'b100, 3'b010, 2'b11};
    // addi x7,x0,2: rs2 field equals the load's rd but I-type does not use rs2
    vt[13] = '{1, 32'h00200393, 32'h134, 0, 0, 5'd0, 32'h0,
               1, 32'h0, 32'h0, 32'h2, 5'd7, 3'b110, 3'b000, 2'b10};

    // Reset held across a couple of edges
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ifid_valid = vt[i].v;
      ifid_inst  = vt[i].inst;
      ifid_pc    = vt[i].pc;
      flush      = vt[i].fl;
      we         = vt[i].we;
      wreg       = vt[i].wr;
      wdata      = vt[i].wd;
      #1;
      chk($sformatf("v%0d_stall", i), 64'(stall), 64'd0);
      tick();
      chk($sformatf("v%0d_valid", i), 64'(valid), 64'(vt[i].e_v));
      chk($sformatf("v%0d_pc", i), 64'(pc), 64'(vt[i].fl ? 32'h0 : vt[i].pc));
      chk($sformatf("v%0d_d1", i), 64'(d1), 64'(vt[i].e_d1));
      chk($sformatf("v%0d_d2", i), 64'(d2), 64'(vt[i].e_d2));
      chk($sformatf("v%0d_imm", i), 64'(imm), 64'(vt[i].e_imm));
      chk($sformatf("v%0d_rd", i), 64'(rd), 64'(vt[i].e_rd));
      chk($sformatf("v%0d_ex", i), 64'(exc), 64'(vt[i].e_ex));
      chk($sformatf("v%0d_mem", i), 64'(memc), 64'(vt[i].e_mem));
      chk($sformatf("v%0d_wb", i), 64'(wbc), 64'(vt[i].e_wb));
    end

    // Load-use on rs1: lw x2,0(x1) then add x3,x2,x4
    drive(1, 32'h0000A103, 0, 0, 5'd0, 32'h0);
    tick();
    drive(1, 32'h004101B3, 0, 0, 5'd0, 32'h0);
    chk("lu1_stall", 64'(stall), 64'(Hz));
    tick();
    chk("lu1_bubble_valid", 64'(valid), 64'(!Hz));
    chk("lu1_bubble_ctrl", 64'({exc, memc, wbc}), 64'(Hz ? 8'h00 : 8'b010_000_10));
    drive(1, 32'h004101B3, 0, 0, 5'd0, 32'h0);
    chk("lu1_stall_once", 64'(stall), 64'd0);
    tick();
    chk("lu1_issue_valid", 64'(valid), 64'd1);
    chk("lu1_issue_ex", 64'(exc), 64'b010);
    chk("lu1_issue_rd", 64'(rd), 64'd3);

    // Load-use on rs2: lw x2 then add x3,x4,x2
    drive(1, 32'h0000A103, 0, 0, 5'd0, 32'h0);
    tick();
    drive(1, 32'h002201B3, 0, 0, 5'd0, 32'h0);
    chk("lu2_stall", 64'(stall), 64'(Hz));
    tick();
    chk("lu2_valid", 64'(valid), 64'(!Hz));

    // Flush overrides a would-be stall
    drive(1, 32'h0000A103, 0, 0, 5'd0, 32'h0);
    tick();
    drive(1, 32'h004101B3, 1, 0, 5'd0, 32'h0);
    chk("fl_stall", 64'(stall), 64'd0);
    tick();
    chk("fl_valid", 64'(valid), 64'd0);
    chk("fl_ctrl", 64'({exc, memc, wbc}), 64'd0);

    // Load to x0 never stalls; invalid IF/ID never stalls
    drive(1, 32'h0000A003, 0, 0, 5'd0, 32'h0);
    tick();
    drive(1, 32'h000001B3, 0, 0, 5'd0, 32'h0);
    chk("x0_load_stall", 64'(stall), 64'd0);
    drive(1, 32'h0000A103, 0, 0, 5'd0, 32'h0);
    tick();
    drive(0, 32'h004101B3, 0, 0, 5'd0, 32'h0);
    chk("inv_stall", 64'(stall), 64'd0);
    tick();
    chk("inv_valid", 64'(valid), 64'd0);
    chk("inv_ctrl", 64'({exc, memc, wbc}), 64'd0);

    // Asynchronous reset mid-stream, then regfile reads back 0
    drive(1, 32'h00028333, 0, 0, 5'd0, 32'h0);
    tick();
    chk("pre_rst_valid", 64'(valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n      = 1'b1;
    ifid_valid = 1'b1;
    ifid_inst  = 32'h00028333;
    tick();
    chk("post_rst_valid", 64'(valid), 64'd1);
    chk("post_rst_x5", 64'(d1), 64'd0);
    chk("post_rst_ex", 64'(exc), 64'b010);

    // NREGS=16: x20 is unimplemented in dut16 but real in dut
    drive(1, 32'h000A00B3, 0, 1, 5'd20, 32'hCAFEF00D);
    tick();
    chk("n16_bypass", 64'(d1_s), 64'd0);
    chk("n32_bypass", 64'(d1), 64'hCAFEF00D);
    drive(1, 32'h000A00B3, 0, 0, 5'd0, 32'h0);
    tick();
    chk("n16_read", 64'(d1_s), 64'd0);
    chk("n32_read", 64'(d1), 64'hCAFEF00D);
    drive(1, 32'h0000AA03, 0, 0, 5'd0, 32'h0);
    tick();
    drive(1, 32'h000A00B3, 0, 0, 5'd0, 32'h0);
    chk("n16_stall", 64'(stall_s), 64'(Hz));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
